if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Fetch-side consumer of the next-PC bus: holds the architectural fetch PC and drives the instruction-memory address.
- Selects between sequential PC+4 and the redirect target computed in D.
- Owns the IF/ID pipeline register, supplying InstrD and PC_D (fetch PC + 4) back to the D stage and the next-PC logic.
- Adds stall hold, a post-reset boot bubble and an out-of-range/misaligned fetch fault.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded by reset.
- IM_DEPTH, 1024, instruction memory size in 32-bit words.
- NOP_INSTR, 32'h0000_0000, encoding injected as a bubble.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit stall; freezes PC and IF/ID
- redirect_D  input  1  D-stage instruction is a branch/jump/jr/jalr; use new_PC
- new_PC  input  32  next-PC target from the D-stage next-PC logic
- Instr_F  input  32  instruction word returned combinationally by IM for PC_F
- PC_F  output  32  current fetch PC; also the IM address
- InstrD  output  32  IF/ID instruction
- PC_D  output  32  IF/ID fetch PC + 4
- PC8_D  output  32  IF/ID fetch PC + 8 (link value)
- fault  output  1  sticky fetch-fault flag
- fault_pc  output  32  PC that caused the fault

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - PC_F=PC_RESET, InstrD=NOP_INSTR, PC_D=PC_RESET, PC8_D=PC_RESET+4, fault=0, fault_pc=0, state=BOOT.
- States: BOOT, RUN, FAULT.
- BOOT lasts exactly one cycle after reset deasserts.
  - IF/ID loads Instr_F/PC_F+4/PC_F+8 normally; PC_F advances to PC_F+4.
  - stall is ignored in BOOT because D holds NOP.
  - Transitions to RUN.
- RUN, next PC selection:
  - stall=1: PC_F and IF/ID all hold, whatever redirect_D is. The redirect is re-presented next cycle because D holds the same instruction.
  - stall=0, redirect_D=1: PC_F<=new_PC.
  - stall=0, redirect_D=0: PC_F<=PC_F+4.
- RUN, IF/ID load (when stall=0): InstrD<=Instr_F, PC_D<=PC_F+4, PC8_D<=PC_F+8.
  - The delay-slot instruction is fetched normally; there is never a flush on redirect.
- Fault check, combinational on PC_F:
  - bad = (PC_F[1:0]!=0) or (PC_F<PC_RESET) or (PC_F>=PC_RESET+4*IM_DEPTH).
- bad=1 in RUN with stall=0:
  - InstrD<=NOP_INSTR; PC_D and PC8_D load normally.
  - fault<=1 and fault_pc<=PC_F; PC_F holds; state->FAULT.
- bad=1 in RUN with stall=1: nothing happens until the stall releases.
- FAULT:
  - PC_F holds and InstrD<=NOP_INSTR every unstalled cycle.
  - fault stays 1; fault_pc is frozen.
  - Exit only by reset.
- Arithmetic: all adds are 32-bit modulo 2^32. Wrap at 32'hFFFF_FFFC gives 0, which is out of range and therefore faults.
- Latency: the redirect takes effect on the PC_F one cycle after the cycle in which redirect_D is sampled with stall=0.
- Reset during stall or FAULT: reset wins and returns to the reset values and BOOT.

Decomposition:
- Shared package (cpu_defs), holding:
  - PC_RESET, IM_DEPTH, NOP_INSTR constants;
  - the 2-bit state encoding (BOOT=0, RUN=1, FAULT=2);
  - the NPC_sel encodings used by the D-stage next-PC logic, so redirect_D decode stays consistent.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with enable (=~stall) and bubble input. The PC register, selection mux, fault check and FSM stay in the top.

Test Plan:
- Reset then 4 free cycles, Instr_F tied to PC-derived pattern:
  - PC_F goes 3000, 3004, 3008, 300C.
  - InstrD=0 during the reset cycle.
  - PC_D=3004 when InstrD holds the word for 3000; PC8_D=3008.
- Branch with delay slot: redirect_D=1, new_PC=3040 while PC_F=3008.
  - Next PC_F=3040.
  - InstrD sequence shows the 3008 word (delay slot), then the 3040 word, with no NOP inserted.
- Stall with pending redirect: stall=1 for 2 cycles, redirect_D=1, new_PC=3100, PC_F=3010.
  - PC_F and InstrD unchanged for both cycles.
  - On stall release PC_F=3100 one cycle later.
- Misaligned jr target: new_PC=3022.
  - Next cycle PC_F=3022; the following cycle fault=1, fault_pc=3022, InstrD=NOP.
  - PC_F stays 3022 for 10 further cycles.
- Out-of-range: PC_F reaches PC_RESET+4*IM_DEPTH (4000 with defaults) by sequential fetch.
  - fault=1, fault_pc=4000, NOPs thereafter.
- Reset asserted while in FAULT with stall=1:
  - Next edge gives PC_F=3000, fault=0, fault_pc=0, InstrD=0.
  - One BOOT cycle, then normal fetching from 3004.

Source files
------------

// File: rtl/if_stage_pkg.sv
// cpu_defs: definitions shared by the fetch stage and the D-stage next-PC logic.
//   DEF_PC_RESET / DEF_IM_DEPTH / DEF_NOP_INSTR : default fetch-stage parameters
//   state_t      : fetch-stage FSM encoding
//   npc_sel_t    : next-PC source select driven by the D-stage decoder
//   npc_redirect : which npc_sel_t values raise redirect_D
package cpu_defs;

  localparam logic [31:0] DEF_PC_RESET  = 32'h0000_3000;
  localparam int unsigned DEF_IM_DEPTH  = 1024;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,  // PC+4
    NPC_BRANCH = 2'd1,  // taken conditional branch
    NPC_JUMP   = 2'd2,  // j / jal
    NPC_JR     = 2'd3   // jr / jalr
  } npc_sel_t;

  function automatic logic npc_redirect(input npc_sel_t sel);
    return (sel != NPC_SEQ);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, reset      : clock, synchronous active-high reset
//   en              : load enable (deasserted while the pipe is stalled)
//   bubble          : load NOP_INSTR instead of the fetched word
//   instr_in        : fetched instruction word
//   pc4_in, pc8_in  : fetch PC + 4 / + 8
//   instr_q, pc4_q, pc8_q : registered values for the D stage
module if_id_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] pc8_in,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic [31:0] pc8_q
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic [31:0] r_pc8;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= PC_RESET;
      r_pc8   <= PC_RESET + 32'd4;
    end else if (en) begin
      r_instr <= bubble ? NOP_INSTR : instr_in;
      r_pc4   <= pc4_in;
      r_pc8   <= pc8_in;
    end
  end

  assign instr_q = r_instr;
  assign pc4_q   = r_pc4;
  assign pc8_q   = r_pc8;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
//   Holds the fetch PC (also the IM address), picks PC+4 or the D-stage
//   redirect target, owns the IF/ID register, and latches a sticky fault when
//   the fetch PC is misaligned or outside instruction memory.
//   clk, reset         : clock, synchronous active-high reset
//   stall              : freeze PC and IF/ID
//   redirect_D, new_PC : D-stage redirect request and its target
//   Instr_F            : IM read data for PC_F
//   PC_F               : fetch PC / IM address
//   InstrD, PC_D, PC8_D: IF/ID contents (instruction, PC+4, PC+8)
//   fault, fault_pc    : sticky fetch fault and the offending PC
//
// state    | meaning
// ST_BOOT  | first cycle after reset, stall ignored, always fetch sequentially
// ST_RUN   | normal fetch, redirect and fault checking
// ST_FAULT | PC frozen, NOPs fed to D until reset
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
  parameter int unsigned IM_DEPTH  = DEF_IM_DEPTH,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_D,
  input  logic [31:0] new_PC,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] InstrD,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        fault,
  output logic [31:0] fault_pc
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_END = PC_RESET + (32'(IM_DEPTH) << 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_pc8;
  logic        w_bad;
  logic        w_ifid_en;
  logic        w_bubble;
  logic        w_fault_set;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  assign w_pc4 = r_pc + 32'd4;
  assign w_pc8 = r_pc + 32'd8;
  assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) || (r_pc >= PC_END);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ifid_en   = 1'b0;
    w_bubble    = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // D holds the reset NOP, so there is nothing a stall could protect.
        w_ifid_en   = 1'b1;
        w_pc_nxt    = w_pc4;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A stalled redirect is re-presented next cycle, so it is safe to drop.
        if (!stall) begin
          w_ifid_en = 1'b1;
          if (w_bad) begin
            w_bubble    = 1'b1;
            w_fault_set = 1'b1;
            w_state_nxt = ST_FAULT;
          end else if (redirect_D) begin
            w_pc_nxt = new_PC;
          end else begin
            w_pc_nxt = w_pc4;
          end
        end
      end
      ST_FAULT: begin
        if (!stall) begin
          w_ifid_en = 1'b1;
          w_bubble  = 1'b1;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'd0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_fault_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
      end
    end
  end

  if_id_reg #(
    .PC_RESET  (PC_RESET),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .en       (w_ifid_en),
    .bubble   (w_bubble),
    .instr_in (Instr_F),
    .pc4_in   (w_pc4),
    .pc8_in   (w_pc8),
    .instr_q  (InstrD),
    .pc4_q    (PC_D),
    .pc8_q    (PC8_D)
  );

  assign PC_F     = r_pc;
  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
// IM is modelled as a PC-derived word so every fetched instruction is distinct.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_D;
  logic [31:0] new_PC;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] InstrD;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        fault;
  logic [31:0] fault_pc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        red;
    logic [31:0] npc;
    logic [31:0] e_pc;    // expected PC_F after the edge
    logic        e_nop;   // expected InstrD is the NOP bubble
    logic [31:0] e_idpc;  // fetch PC held in IF/ID (PC_D = +4, PC8_D = +8)
    logic        e_flt;
    logic [31:0] e_fpc;
  } vec_t;

  vec_t vq[$];

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect_D (redirect_D),
    .new_PC     (new_PC),
    .Instr_F    (Instr_F),
    .PC_F       (PC_F),
    .InstrD     (InstrD),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  function automatic logic [31:0] im(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  assign Instr_F = im(PC_F);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input logic rd,
                              input logic [31:0] npc, input logic [31:0] epc,
                              input logic enop, input logic [31:0] eid,
                              input logic eflt, input logic [31:0] efpc);
    vec_t v;
    v.rst = r; v.stl = s; v.red = rd; v.npc = npc;
    v.e_pc = epc; v.e_nop = enop; v.e_idpc = eid; v.e_flt = eflt; v.e_fpc = efpc;
    vq.push_back(v);
  endfunction

  task automatic chk(input string tag, input string name,
                     input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %08h expected %08h", tag, name, got, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; stall = v.stl; redirect_D = v.red; new_PC = v.npc;
    @(posedge clk);
    #1;
    n_vec++;
    chk(tag, "PC_F",     PC_F,     v.e_pc);
    chk(tag, "InstrD",   InstrD,   v.e_nop ? 32'h0000_0000 : im(v.e_idpc));
    chk(tag, "PC_D",     PC_D,     v.e_idpc + 32'd4);
    chk(tag, "PC8_D",    PC8_D,    v.e_idpc + 32'd8);
    chk(tag, "fault",    {31'd0, fault}, {31'd0, v.e_flt});
    chk(tag, "fault_pc", fault_pc, v.e_fpc);
  endtask

  task automatic hstep(input logic r, input logic s, input logic rd,
                       input logic [31:0] npc, input logic [31:0] epc,
                       input logic enop, input logic [31:0] eid,
                       input logic eflt, input logic [31:0] efpc,
                       input string tag);
    vec_t v;
    v.rst = r; v.stl = s; v.red = rd; v.npc = npc;
    v.e_pc = epc; v.e_nop = enop; v.e_idpc = eid; v.e_flt = eflt; v.e_fpc = efpc;
    step(v, tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_D = 1'b0; new_PC = 32'd0;

    // reset, boot, free run
    add(1,0,0,32'h0,    32'h3000,1,32'h2FFC,0,32'h0);
    add(0,0,0,32'h0,    32'h3004,0,32'h3000,0,32'h0);
    add(0,0,0,32'h0,    32'h3008,0,32'h3004,0,32'h0);
    // branch at 3008 with delay slot
    add(0,0,1,32'h3040, 32'h3040,0,32'h3008,0,32'h0);
    add(0,0,0,32'h0,    32'h3044,0,32'h3040,0,32'h0);
    // get to 3010, then stall with a pending redirect to 3100
    add(0,0,1,32'h3010, 32'h3010,0,32'h3044,0,32'h0);
    add(0,1,1,32'h3100, 32'h3010,0,32'h3044,0,32'h0);
    add(0,1,1,32'h3100, 32'h3010,0,32'h3044,0,32'h0);
    add(0,0,1,32'h3100, 32'h3100,0,32'h3010,0,32'h0);
    add(0,0,0,32'h0,    32'h3104,0,32'h3100,0,32'h0);
    // misaligned jr target
    add(0,0,1,32'h3022, 32'h3022,0,32'h3104,0,32'h0);
    add(0,0,0,32'h0,    32'h3022,1,32'h3022,1,32'h3022);
    for (int i = 0; i < 10; i++)
      add(0, i[0], 1, 32'h3000, 32'h3022,1,32'h3022,1,32'h3022);
    // reset while faulted and stalled, BOOT ignores stall
    add(1,1,0,32'h0,    32'h3000,1,32'h2FFC,0,32'h0);
    add(0,1,0,32'h0,    32'h3004,0,32'h3000,0,32'h0);
    add(0,0,0,32'h0,    32'h3008,0,32'h3004,0,32'h0);
    add(0,0,0,32'h0,    32'h300C,0,32'h3008,0,32'h0);

    for (int i = 0; i < vq.size(); i++)
      step(vq[i], $sformatf("vec%0d", i));

    // upper bound reached by sequential fetch; stalls defer the fault
    hstep(1,0,0,32'h0,    32'h3000,1,32'h2FFC,0,32'h0,    "oor_rst");
    hstep(0,0,0,32'h0,    32'h3004,0,32'h3000,0,32'h0,    "oor_boot");
    hstep(0,0,1,32'h3FF8, 32'h3FF8,0,32'h3004,0,32'h0,    "oor_jmp");
    hstep(0,0,0,32'h0,    32'h3FFC,0,32'h3FF8,0,32'h0,    "oor_seq1");
    hstep(0,0,0,32'h0,    32'h4000,0,32'h3FFC,0,32'h0,    "oor_seq2");
    hstep(0,1,0,32'h0,    32'h4000,0,32'h3FFC,0,32'h0,    "oor_stl1");
    hstep(0,1,1,32'h3000, 32'h4000,0,32'h3FFC,0,32'h0,    "oor_stl2");
    hstep(0,0,0,32'h0,    32'h4000,1,32'h4000,1,32'h4000, "oor_flt");
    hstep(0,0,1,32'h3000, 32'h4000,1,32'h4000,1,32'h4000, "oor_hold");
    hstep(0,0,0,32'h0,    32'h4000,1,32'h4000,1,32'h4000, "oor_nop");

    // lower bound: last word below PC_RESET
    hstep(1,0,0,32'h0,    32'h3000,1,32'h2FFC,0,32'h0,    "low_rst");
    hstep(0,0,0,32'h0,    32'h3004,0,32'h3000,0,32'h0,    "low_boot");
    hstep(0,0,1,32'h2FFC, 32'h2FFC,0,32'h3004,0,32'h0,    "low_jmp");
    hstep(0,0,0,32'h0,    32'h2FFC,1,32'h2FFC,1,32'h2FFC, "low_flt");

    // last valid word does not fault
    hstep(1,0,0,32'h0,    32'h3000,1,32'h2FFC,0,32'h0,    "top_rst");
    hstep(0,0,0,32'h0,    32'h3004,0,32'h3000,0,32'h0,    "top_boot");
    hstep(0,0,1,32'h3FFC, 32'h3FFC,0,32'h3004,0,32'h0,    "top_jmp");
    hstep(0,0,1,32'h3200, 32'h3200,0,32'h3FFC,0,32'h0,    "top_ok");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
